traffic_phase_scheduler: RTL and testbench

Demand-actuated phase scheduler for the four-group intersection (main road M1, main road M2, M2 turn MT, side road S). Main road rests green by default. Latched side-road and turn requests are served after a minimum main green. An emergency input preempts everything to all-red. It drives the same 3-bit light groups as the fixed-time Traffic_Light_Controller and replaces it where sensors are fitted. One tick is one clk cycle, nominally 1 s.

---
 rtl/traffic_phase_scheduler_pkg.sv | 49 ++++
 rtl/traffic_phase_scheduler_if.sv | 22 ++
 rtl/traffic_phase_scheduler_phase_timer.sv | 23 ++
 rtl/traffic_phase_scheduler.sv | 154 +++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types for the demand-actuated phase scheduler: state codes,
// lamp encodings, ALL_RED target encoding and the state-to-lamp table.
package traffic_pkg;

    typedef enum logic [3:0] {
        MAIN_GRN = 4'd0,
        MAIN_YEL = 4'd1,
        M1_YEL   = 4'd2,
        TURN_GRN = 4'd3,
        TURN_YEL = 4'd4,
        SIDE_GRN = 4'd5,
        SIDE_YEL = 4'd6,
        ALL_RED  = 4'd7,
        PREEMPT  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        TGT_MAIN    = 2'd0,
        TGT_SIDE    = 2'd1,
        TGT_PREEMPT = 2'd2
    } target_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef struct packed {
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] mt;
        logic [2:0] s;
    } lamps_t;

    function automatic lamps_t lamps_of(input state_t st);
        lamps_t l;
        case (st)
            MAIN_GRN: l = '{m1: GRN, m2: GRN, mt: RED, s: RED};
            MAIN_YEL: l = '{m1: YEL, m2: YEL, mt: RED, s: RED};
            M1_YEL:   l = '{m1: YEL, m2: GRN, mt: RED, s: RED};
            TURN_GRN: l = '{m1: RED, m2: GRN, mt: GRN, s: RED};
            TURN_YEL: l = '{m1: RED, m2: YEL, mt: YEL, s: RED};
            SIDE_GRN: l = '{m1: RED, m2: RED, mt: RED, s: GRN};
            SIDE_YEL: l = '{m1: RED, m2: RED, mt: RED, s: YEL};
            default:  l = '{m1: RED, m2: RED, mt: RED, s: RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request inputs and lamp/status outputs of the phase scheduler.
interface traffic_phase_scheduler_if;
    logic       side_req;
    logic       turn_req;
    logic       emerg;
    logic [2:0] light_M1;
    logic [2:0] light_M2;
    logic [2:0] light_MT;
    logic [2:0] light_S;
    logic [3:0] phase;
    logic [1:0] dmd;

    modport master (
        output side_req, turn_req, emerg,
        input  light_M1, light_M2, light_MT, light_S, phase, dmd
    );

    modport slave (
        input  side_req, turn_req, emerg,
        output light_M1, light_M2, light_MT, light_S, phase, dmd
    );
endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Phase duration down-counter: loads on state entry, saturates at zero.
module phase_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          clk,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-group phase scheduler with latched side/turn demands
// and emergency preemption to all-red.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned MAIN_MIN = 7,
    parameter int unsigned TURN_T   = 5,
    parameter int unsigned SIDE_T   = 7,
    parameter int unsigned YEL_T    = 2,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned TW       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    traffic_phase_scheduler_if.slave  bus
);

    state_t        state, nxt_state;
    target_t       target, nxt_target;
    lamps_t        lamps;
    logic          turn_dmd, side_dmd;
    logic          tmr_zero, tmr_load;
    logic [TW-1:0] tmr_val;

    function automatic logic [TW-1:0] dur_of(input state_t st);
        case (st)
            MAIN_GRN:                   return TW'(MAIN_MIN - 1);
            MAIN_YEL, M1_YEL,
            TURN_YEL, SIDE_YEL:         return TW'(YEL_T - 1);
            TURN_GRN:                   return TW'(TURN_T - 1);
            SIDE_GRN:                   return TW'(SIDE_T - 1);
            ALL_RED:                    return TW'(ALLRED_T - 1);
            default:                    return '0;
        endcase
    endfunction

    // Yellows only leave on timer zero, so emerg never shortens them.
    always_comb begin
        nxt_state  = state;
        nxt_target = target;
        case (state)
            MAIN_GRN: begin
                if (bus.emerg) begin
                    nxt_state  = MAIN_YEL;
                    nxt_target = TGT_PREEMPT;
                end else if (tmr_zero && turn_dmd) begin
                    nxt_state = M1_YEL;
                end else if (tmr_zero && side_dmd) begin
                    nxt_state  = MAIN_YEL;
                    nxt_target = TGT_SIDE;
                end
            end
            M1_YEL: begin
                if (tmr_zero) begin
                    if (bus.emerg) begin
                        nxt_state  = MAIN_YEL;
                        nxt_target = TGT_PREEMPT;
                    end else begin
                        nxt_state = TURN_GRN;
                    end
                end
            end
            TURN_GRN: begin
                if (bus.emerg || tmr_zero) nxt_state = TURN_YEL;
            end
            TURN_YEL: begin
                if (tmr_zero) begin
                    nxt_state = ALL_RED;
                    if (bus.emerg)     nxt_target = TGT_PREEMPT;
                    else if (side_dmd) nxt_target = TGT_SIDE;
                    else               nxt_target = TGT_MAIN;
                end
            end
            SIDE_GRN: begin
                if (bus.emerg || tmr_zero) nxt_state = SIDE_YEL;
            end
            SIDE_YEL: begin
                if (tmr_zero) begin
                    nxt_state  = ALL_RED;
                    nxt_target = bus.emerg ? TGT_PREEMPT : TGT_MAIN;
                end
            end
            MAIN_YEL: begin
                if (tmr_zero) nxt_state = ALL_RED;
            end
            ALL_RED: begin
                if (tmr_zero) begin
                    if (bus.emerg) begin
                        nxt_state = PREEMPT;
                    end else begin
                        case (target)
                            TGT_SIDE:    nxt_state = SIDE_GRN;
                            TGT_PREEMPT: nxt_state = PREEMPT;
                            default:     nxt_state = MAIN_GRN;
                        endcase
                    end
                end
            end
            PREEMPT: begin
                if (!bus.emerg) begin
                    nxt_state  = ALL_RED;
                    nxt_target = TGT_MAIN;
                end
            end
            default: begin
                nxt_state  = ALL_RED;
                nxt_target = TGT_MAIN;
            end
        endcase
    end

    assign tmr_load = !rst || (nxt_state != state);
    assign tmr_val  = !rst ? TW'(ALLRED_T - 1) : dur_of(nxt_state);

    phase_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Entering the matching green clears its demand, even against a same-cycle request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ALL_RED;
            target   <= TGT_MAIN;
            turn_dmd <= 1'b0;
            side_dmd <= 1'b0;
            lamps    <= lamps_of(ALL_RED);
        end else begin
            state  <= nxt_state;
            target <= nxt_target;
            lamps  <= lamps_of(nxt_state);

            if (nxt_state == SIDE_GRN && state != SIDE_GRN)
                side_dmd <= 1'b0;
            else if (state != SIDE_GRN && bus.side_req)
                side_dmd <= 1'b1;

            if (nxt_state == TURN_GRN && state != TURN_GRN)
                turn_dmd <= 1'b0;
            else if (state != TURN_GRN && bus.turn_req)
                turn_dmd <= 1'b1;
        end
    end

    assign bus.light_M1 = lamps.m1;
    assign bus.light_M2 = lamps.m2;
    assign bus.light_MT = lamps.mt;
    assign bus.light_S  = lamps.s;
    assign bus.phase    = state;
    assign bus.dmd      = {turn_dmd, side_dmd};

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: phase sequences, demand latches,
// preemption, mid-operation reset and a per-cycle conflicting-lamp check.
module tb_traffic_phase_scheduler;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic clk = 1'b0;
    logic rst;
    logic armed = 1'b0;
    int   checks = 0;
    int   errors = 0;

    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] exp_lamps(input logic [3:0] ph);
        case (ph)
            4'd0:    return {G, G, R, R};
            4'd1:    return {Y, Y, R, R};
            4'd2:    return {Y, G, R, R};
            4'd3:    return {R, G, G, R};
            4'd4:    return {R, Y, Y, R};
            4'd5:    return {R, R, R, G};
            4'd6:    return {R, R, R, Y};
            default: return {R, R, R, R};
        endcase
    endfunction

    function automatic logic lit(input logic [2:0] l);
        return (l == G) || (l == Y);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (armed) begin
            checks++;
            assert (!((lit(bus.light_M1) && lit(bus.light_MT)) ||
                      (lit(bus.light_S) && (lit(bus.light_M1) || lit(bus.light_M2) || lit(bus.light_MT)))))
            else begin
                errors++;
                $error("FAIL safety observed=%0h expected=no_conflict",
                       {bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S});
            end
        end
    endtask

    task automatic hold(input string tag, input logic [3:0] ph, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_phase_c%0d", tag, i), 16'(bus.phase), 16'(ph));
            chk($sformatf("%s_lamps_c%0d", tag, i),
                16'({bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S}), 16'(exp_lamps(ph)));
            step();
        end
    endtask

    task automatic chk_dmd(input string tag, input logic [1:0] exp);
        chk(tag, 16'(bus.dmd), 16'(exp));
    endtask

    initial begin
        rst          = 1'b0;
        bus.side_req = 1'b0;
        bus.turn_req = 1'b0;
        bus.emerg    = 1'b0;

        // Reset state
        step();
        chk("rst_phase", 16'(bus.phase), 16'd7);
        chk("rst_lamps", 16'({bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S}), 16'h924);
        chk_dmd("rst_dmd", 2'b00);
        rst   = 1'b1;
        armed = 1'b1;
        hold("boot_ar", 4'd7, 1);

        // Side request in MAIN_GRN cycle 2
        hold("s_mg", 4'd0, 2);
        chk("s_mg_c2", 16'(bus.phase), 16'd0);
        bus.side_req = 1'b1;
        step();
        bus.side_req = 1'b0;
        chk_dmd("s_dmd_set", 2'b01);
        hold("s_mg_rest", 4'd0, 4);
        hold("s_my", 4'd1, 2);
        hold("s_ar1", 4'd7, 1);
        chk_dmd("s_dmd_clr", 2'b00);
        hold("s_sg", 4'd5, 7);
        hold("s_sy", 4'd6, 2);
        hold("s_ar2", 4'd7, 1);

        // Turn and side together in MAIN_GRN cycle 0
        chk("ts_mg_c0", 16'(bus.phase), 16'd0);
        bus.turn_req = 1'b1;
        bus.side_req = 1'b1;
        step();
        bus.turn_req = 1'b0;
        bus.side_req = 1'b0;
        chk_dmd("ts_dmd_set", 2'b11);
        hold("ts_mg", 4'd0, 6);
        hold("ts_m1y", 4'd2, 2);
        chk_dmd("ts_dmd_turn_clr", 2'b01);
        hold("ts_tg", 4'd3, 5);
        hold("ts_ty", 4'd4, 2);
        hold("ts_ar1", 4'd7, 1);
        chk_dmd("ts_dmd_side_clr", 2'b00);
        hold("ts_sg", 4'd5, 7);
        hold("ts_sy", 4'd6, 2);
        hold("ts_ar2", 4'd7, 1);

        // Idle main green
        hold("idle", 4'd0, 50);
        chk_dmd("idle_dmd", 2'b00);

        // Emergency during TURN_GRN with side demand pending
        bus.turn_req = 1'b1;
        step();
        bus.turn_req = 1'b0;
        chk("e_mg_last", 16'(bus.phase), 16'd0);
        chk_dmd("e_dmd_turn", 2'b10);
        step();
        hold("e_m1y", 4'd2, 2);
        chk("e_tg_c0", 16'(bus.phase), 16'd3);
        bus.side_req = 1'b1;
        step();
        bus.side_req = 1'b0;
        chk("e_tg_c1", 16'(bus.phase), 16'd3);
        chk_dmd("e_dmd_side", 2'b01);
        bus.emerg = 1'b1;
        step();
        hold("e_ty", 4'd4, 2);
        hold("e_ar1", 4'd7, 1);
        hold("e_pre", 4'd8, 3);
        chk_dmd("e_dmd_keep", 2'b01);
        bus.emerg = 1'b0;
        hold("e_pre_exit", 4'd8, 1);
        hold("e_ar2", 4'd7, 1);
        chk_dmd("e_dmd_after", 2'b01);
        hold("e_mg", 4'd0, 7);
        hold("e_my", 4'd1, 2);
        hold("e_ar3", 4'd7, 1);

        // Reset during SIDE_GRN cycle 3 with turn demand latched
        chk_dmd("r_dmd_clr", 2'b00);
        chk("r_sg_c0", 16'(bus.phase), 16'd5);
        bus.turn_req = 1'b1;
        step();
        bus.turn_req = 1'b0;
        hold("r_sg", 4'd5, 2);
        chk("r_sg_c3", 16'(bus.phase), 16'd5);
        chk_dmd("r_dmd_turn", 2'b10);
        rst = 1'b0;
        step();
        chk("r_phase", 16'(bus.phase), 16'd7);
        chk("r_lamps", 16'({bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S}), 16'h924);
        chk_dmd("r_dmd", 2'b00);
        rst = 1'b1;
        hold("r_ar", 4'd7, 1);
        chk("r_mg", 16'(bus.phase), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
